// File: rtl/gelato_multi_warp_inst_buffer_if.sv
// Decoder/scheduler-facing bundle of the per-warp instruction buffer.
// The master side drives push/pop/flush requests. The slave side is the buffer itself.
interface gelato_multi_warp_inst_buffer_if #(
   parameter int NUM_WARPS  = 4,
   parameter int INST_WIDTH = 32,
   parameter int WID_W      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
   parameter int CNT_W      = 3
);
   logic                            push_valid;
   logic [WID_W-1:0]                push_warp_id;
   logic [INST_WIDTH-1:0]           push_inst;
   logic                            push_ready;
   logic [NUM_WARPS-1:0]            pop_en;
   logic [NUM_WARPS*INST_WIDTH-1:0] head_inst;
   logic [NUM_WARPS-1:0]            empty;
   logic [NUM_WARPS-1:0]            full;
   logic [NUM_WARPS-1:0]            almost_full;
   logic [NUM_WARPS*CNT_W-1:0]      occupancy;
   logic                            flush_en;
   logic [WID_W-1:0]                flush_warp_id;
   logic [NUM_WARPS-1:0]            err_pop_empty;

   modport master (
      output push_valid, push_warp_id, push_inst, pop_en, flush_en, flush_warp_id,
      input  push_ready, head_inst, empty, full, almost_full, occupancy, err_pop_empty
   );

   modport slave (
      input  push_valid, push_warp_id, push_inst, pop_en, flush_en, flush_warp_id,
      output push_ready, head_inst, empty, full, almost_full, occupancy, err_pop_empty
   );
endinterface

// File: rtl/gelato_multi_warp_inst_buffer.sv
// NUM_WARPS independent FIFOs. A push becomes visible on head_inst 1 cycle later, and pops read the head combinationally.
// Backpressure: push_ready drops when the target warp is full, being flushed, or rdy is low.
module gelato_multi_warp_inst_buffer #(
   parameter int NUM_WARPS          = 4,
   parameter int DEPTH              = 4,
   parameter int INST_WIDTH         = 32,
   parameter int ALMOST_FULL_THRESH = 3,
   parameter int WID_W              = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
   parameter int CNT_W              = $clog2(DEPTH + 1)
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             rdy,
   gelato_multi_warp_inst_buffer_if.slave   bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(ALMOST_FULL_THRESH);

   logic [INST_WIDTH-1:0] mem_q [NUM_WARPS][DEPTH];
   logic [PTR_W-1:0]      head_q [NUM_WARPS];
   logic [PTR_W-1:0]      head_d [NUM_WARPS];
   logic [PTR_W-1:0]      tail_q [NUM_WARPS];
   logic [PTR_W-1:0]      tail_d [NUM_WARPS];
   logic [CNT_W-1:0]      cnt_q  [NUM_WARPS];
   logic [CNT_W-1:0]      cnt_d  [NUM_WARPS];
   logic [NUM_WARPS-1:0]  err_q, err_d;
   logic [NUM_WARPS-1:0]  push_fire, pop_fire, flush_hit, sel;

   always_comb begin
      bus.push_ready = 1'b0;
      err_d          = err_q;
      for (int w = 0; w < NUM_WARPS; w++) begin
         flush_hit[w] = rdy & bus.flush_en & (bus.flush_warp_id == WID_W'(w));
         sel[w]       = (bus.push_warp_id == WID_W'(w));
         // An id beyond NUM_WARPS-1 matches no warp, so push_ready stays low.
         if (sel[w])
            bus.push_ready = rdy & (cnt_q[w] != FULL_CNT) & ~flush_hit[w];
         push_fire[w] = sel[w] & bus.push_valid & rdy & (cnt_q[w] != FULL_CNT) & ~flush_hit[w];
         pop_fire[w]  = rdy & bus.pop_en[w] & (cnt_q[w] != '0) & ~flush_hit[w];
         if (rdy & bus.pop_en[w] & (cnt_q[w] == '0) & ~flush_hit[w])
            err_d[w] = 1'b1;

         head_d[w] = pop_fire[w]  ? head_q[w] + PTR_W'(1) : head_q[w];
         tail_d[w] = push_fire[w] ? tail_q[w] + PTR_W'(1) : tail_q[w];
         case ({push_fire[w], pop_fire[w]})
            2'b10:   cnt_d[w] = cnt_q[w] + CNT_W'(1);
            2'b01:   cnt_d[w] = cnt_q[w] - CNT_W'(1);
            default: cnt_d[w] = cnt_q[w];
         endcase
         if (flush_hit[w]) begin
            head_d[w] = '0;
            tail_d[w] = '0;
            cnt_d[w]  = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= '0;
         for (int w = 0; w < NUM_WARPS; w++) begin
            head_q[w] <= '0;
            tail_q[w] <= '0;
            cnt_q[w]  <= '0;
         end
      end else begin
         err_q <= err_d;
         for (int w = 0; w < NUM_WARPS; w++) begin
            head_q[w] <= head_d[w];
            tail_q[w] <= tail_d[w];
            cnt_q[w]  <= cnt_d[w];
         end
      end
   end

   // Storage is not reset; entries only become observable once counted.
   always_ff @(posedge clk) begin
      for (int w = 0; w < NUM_WARPS; w++)
         if (push_fire[w])
            mem_q[w][tail_q[w]] <= bus.push_inst;
   end

   always_comb begin
      bus.head_inst     = '0;
      bus.occupancy     = '0;
      bus.empty         = '0;
      bus.full          = '0;
      bus.almost_full   = '0;
      bus.err_pop_empty = err_q;
      for (int w = 0; w < NUM_WARPS; w++) begin
         bus.head_inst[w*INST_WIDTH +: INST_WIDTH] = mem_q[w][head_q[w]];
         bus.occupancy[w*CNT_W +: CNT_W]           = cnt_q[w];
         bus.empty[w]       = (cnt_q[w] == '0);
         bus.full[w]        = (cnt_q[w] == FULL_CNT);
         bus.almost_full[w] = (cnt_q[w] >= AF_CNT);
      end
   end
endmodule

// File: tb/tb_gelato_multi_warp_inst_buffer.sv
// Directed bench for the multi-warp instruction buffer.
// A per-warp queue scoreboard predicts heads, flags and occupancy.
module tb_gelato_multi_warp_inst_buffer;
   localparam int NW = 4;
   localparam int D  = 4;
   localparam int IW = 32;
   localparam int WW = 2;
   localparam int CW = 3;

   logic clk = 1'b0;
   logic rst_n;
   logic rdy;
   always #5 clk = ~clk;

   gelato_multi_warp_inst_buffer_if #(.NUM_WARPS(NW), .INST_WIDTH(IW), .WID_W(WW), .CNT_W(CW)) bus ();

   gelato_multi_warp_inst_buffer #(
      .NUM_WARPS(NW), .DEPTH(D), .INST_WIDTH(IW), .ALMOST_FULL_THRESH(3), .WID_W(WW), .CNT_W(CW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .rdy(rdy), .bus(bus)
   );

   int checks = 0;
   int errors = 0;
   logic [31:0]   sb [NW][$];
   logic [NW-1:0] err_m;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] hd(input int w);
      return bus.head_inst[w*IW +: IW];
   endfunction

   task automatic check_state();
      logic [NW-1:0]    e_empty, e_full, e_af;
      logic [NW*CW-1:0] e_occ;
      for (int w = 0; w < NW; w++) begin
         e_empty[w] = (sb[w].size() == 0);
         e_full[w]  = (sb[w].size() == D);
         e_af[w]    = (sb[w].size() >= 3);
         e_occ[w*CW +: CW] = CW'(sb[w].size());
         if (sb[w].size() > 0) chk($sformatf("head_inst[%0d]", w), hd(w), sb[w][0]);
      end
      chk("empty", bus.empty, e_empty);
      chk("full", bus.full, e_full);
      chk("almost_full", bus.almost_full, e_af);
      chk("occupancy", bus.occupancy, e_occ);
      chk("err_pop_empty", bus.err_pop_empty, err_m);
   endtask

   // One clock of stimulus: check push_ready and popped heads before the edge, update the model, check state after.
   task automatic cyc(input logic pv, input int pw, input logic [31:0] pd, input logic [NW-1:0] pe,
                      input logic fe, input int fw, input logic r);
      logic exp_rdy;
      rdy                = r;
      bus.push_valid     = pv;
      bus.push_warp_id   = WW'(pw);
      bus.push_inst      = pd;
      bus.pop_en         = pe;
      bus.flush_en       = fe;
      bus.flush_warp_id  = WW'(fw);
      #1;
      exp_rdy = r && (sb[pw].size() < D) && !(fe && fw == pw);
      chk("push_ready", bus.push_ready, exp_rdy);
      for (int w = 0; w < NW; w++)
         if (pe[w] && sb[w].size() > 0) chk($sformatf("pop_head[%0d]", w), hd(w), sb[w][0]);
      @(posedge clk);
      #1;
      if (r) begin
         for (int w = 0; w < NW; w++) begin
            if (fe && fw == w) sb[w].delete();
            else if (pe[w]) begin
               if (sb[w].size() > 0) void'(sb[w].pop_front());
               else err_m[w] = 1'b1;
            end
         end
         if (pv && exp_rdy) sb[pw].push_back(pd);
      end
      bus.push_valid = 1'b0;
      bus.pop_en     = '0;
      bus.flush_en   = 1'b0;
      check_state();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      for (int w = 0; w < NW; w++) sb[w].delete();
      err_m = '0;
      check_state();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rdy = 1'b1;
      bus.push_valid = 1'b0; bus.push_warp_id = '0; bus.push_inst = '0;
      bus.pop_en = '0; bus.flush_en = 1'b0; bus.flush_warp_id = '0;
      err_m = '0;
      do_reset();
      #1;
      chk("reset_push_ready", bus.push_ready, 1'b1);
      check_state();

      // Fill warp 2, confirm it refuses more, then drain in order.
      for (int i = 0; i < 4; i++) cyc(1'b1, 2, 32'hA0 + i, '0, 1'b0, 0, 1'b1);
      cyc(1'b0, 2, 32'h0, '0, 1'b0, 0, 1'b1);
      for (int i = 0; i < 4; i++) cyc(1'b0, 0, 32'h0, 4'b0100, 1'b0, 0, 1'b1);

      // Full warp 1: simultaneous push is refused while the pop fires.
      for (int i = 0; i < 4; i++) cyc(1'b1, 1, 32'hB0 + i, '0, 1'b0, 0, 1'b1);
      cyc(1'b1, 1, 32'hB4, 4'b0010, 1'b0, 0, 1'b1);
      cyc(1'b1, 1, 32'hB4, '0, 1'b0, 0, 1'b1);

      // Flush warp 0 while pushing and popping it; warp 3 untouched.
      cyc(1'b1, 3, 32'hC0, '0, 1'b0, 0, 1'b1);
      cyc(1'b1, 3, 32'hC1, '0, 1'b0, 0, 1'b1);
      cyc(1'b1, 0, 32'hD0, '0, 1'b0, 0, 1'b1);
      cyc(1'b1, 0, 32'hD1, '0, 1'b0, 0, 1'b1);
      cyc(1'b1, 0, 32'hD2, 4'b0001, 1'b1, 0, 1'b1);

      // Drain warp 3, then pop it empty: sticky error.
      cyc(1'b0, 0, 32'h0, 4'b1000, 1'b0, 0, 1'b1);
      cyc(1'b0, 0, 32'h0, 4'b1000, 1'b0, 0, 1'b1);
      cyc(1'b0, 0, 32'h0, 4'b1000, 1'b0, 0, 1'b1);
      cyc(1'b1, 3, 32'hE0, '0, 1'b0, 0, 1'b1);
      cyc(1'b0, 0, 32'h0, 4'b1000, 1'b0, 0, 1'b1);

      // Pointer wrap on warp 0, with a frozen rdy-low cycle mid-stream.
      cyc(1'b1, 0, 32'h10, '0, 1'b0, 0, 1'b1);
      for (int i = 1; i < 10; i++) begin
         if (i == 5) cyc(1'b1, 0, 32'h99, 4'b0001, 1'b0, 0, 1'b0);
         cyc(1'b1, 0, 32'h10 + i, 4'b0001, 1'b0, 0, 1'b1);
      end
      cyc(1'b0, 0, 32'h0, 4'b0001, 1'b0, 0, 1'b1);

      // Reset clears the sticky error and all queues.
      do_reset();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
